// File: rtl/bitstream_tx_scheduler_pkg.sv
// ============================================================================
// Module : bitstream_tx_scheduler_pkg
// Brief  : Shared types and round-robin pick helper for the bitstream TX scheduler
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bitstream_tx_scheduler_pkg;

    localparam int BYTE_W_DEF  = 8;
    localparam int RR_MAX_REQ  = 8;
    localparam int RR_IDX_W    = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // Scans ptr, ptr+1, ... mod num_req; walking backwards lets the nearest hit win.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                         input logic [RR_IDX_W-1:0]   ptr,
                                         input int                    num_req);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = num_req - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % num_req;
            if (valid[idx]) begin
                r.found = 1'b1;
                r.idx   = RR_IDX_W'(idx);
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bitstream_tx_scheduler_rr_arbiter.sv
// ============================================================================
// Module : bitstream_tx_scheduler_rr_arbiter
// Brief  : Combinational round-robin pick of one requester starting at ptr
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bitstream_tx_scheduler_rr_arbiter
    import bitstream_tx_scheduler_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [ID_W-1:0]    grant_o,
    output logic               found_o
);

    logic [RR_MAX_REQ-1:0] w_valid;
    rr_pick_t              w_pick;

    always_comb begin
        w_valid                = '0;
        w_valid[NUM_REQ-1:0]   = valid_i;
        w_pick                 = rr_pick(w_valid, RR_IDX_W'(ptr_i), NUM_REQ);
        grant_o                = ID_W'(w_pick.idx);
        found_o                = w_pick.found;
    end

endmodule

`default_nettype wire

// File: rtl/bitstream_tx_scheduler.sv
// ============================================================================
// Module : bitstream_tx_scheduler
// Brief  : Round-robin sharing of one LSB-first byte serializer among NUM_REQ sources
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bitstream_tx_scheduler
    import bitstream_tx_scheduler_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int BYTE_W    = BYTE_W_DEF,
    parameter  int MAX_BURST = 4,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*BYTE_W-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]          req_last_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic                        data_out_o,
    output logic                        data_out_valid_o,
    output logic [ID_W-1:0]             src_id_o,
    output logic                        busy_o
);

    localparam int CNT_W   = $clog2(BYTE_W);
    localparam int BURST_W = 4;

    state_e             state_q,   state_d;
    logic [BYTE_W-1:0]  sreg_q,    sreg_d;
    logic [ID_W-1:0]    owner_q,   owner_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BURST_W-1:0] burst_q,   burst_d;
    logic               last_q,    last_d;
    logic [ID_W-1:0]    ptr_q,     ptr_d;

    logic [ID_W-1:0]    w_grant;
    logic               w_found;
    logic               w_at_last;
    logic               w_cont;
    logic [ID_W-1:0]    w_owner_inc;

    bitstream_tx_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (w_grant),
        .found_o (w_found)
    );

    assign w_at_last   = (state_q == SHIFT) && (bit_cnt_q == CNT_W'(BYTE_W - 1));
    // Continuation keeps the owner without a gap bit when its frame is still going.
    assign w_cont      = w_at_last && req_valid_i[owner_q] && !last_q
                         && (burst_q < BURST_W'(MAX_BURST));
    assign w_owner_inc = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            owner_q   <= '0;
            bit_cnt_q <= '0;
            burst_q   <= '0;
            last_q    <= 1'b0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            owner_q   <= owner_d;
            bit_cnt_q <= bit_cnt_d;
            burst_q   <= burst_d;
            last_q    <= last_d;
            ptr_q     <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        owner_d   = owner_q;
        bit_cnt_d = bit_cnt_q;
        burst_d   = burst_q;
        last_d    = last_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                if (w_found) begin
                    state_d   = SHIFT;
                    sreg_d    = req_data_i[w_grant*BYTE_W +: BYTE_W];
                    owner_d   = w_grant;
                    bit_cnt_d = '0;
                    burst_d   = BURST_W'(1);
                    last_d    = req_last_i[w_grant];
                end
            end
            SHIFT: begin
                if (!w_at_last) begin
                    sreg_d    = sreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end else if (w_cont) begin
                    sreg_d    = req_data_i[owner_q*BYTE_W +: BYTE_W];
                    bit_cnt_d = '0;
                    burst_d   = burst_q + BURST_W'(1);
                    last_d    = req_last_i[owner_q];
                end else begin
                    state_d   = IDLE;
                    ptr_d     = w_owner_inc;
                    burst_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_out_o       = (state_q == SHIFT) & sreg_q[0];
        data_out_valid_o = (state_q == SHIFT);
        busy_o           = (state_q == SHIFT);
        src_id_o         = (state_q == SHIFT) ? owner_q : '0;
        req_ready_o      = '0;
        if (!rst) begin
            if ((state_q == IDLE) && w_found) begin
                req_ready_o[w_grant] = 1'b1;
            end else if (w_cont) begin
                req_ready_o[owner_q] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
